// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle short, double and long press pulses.
// Define AUTO_REPEAT_EN to add periodic repeat_pulse while a long press is held.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 12_500_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic pressed,
    output logic busy,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse
);

    // state    | meaning
    // IDLE     | no press in progress
    // PRESS1   | first press held, counting high samples toward long press
    // WAIT_GAP | first press released, counting low samples toward short press
    // PRESS2   | second press held, resolves as double press
    // HOLD     | press already classified, waiting for release
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS1   = 3'd1,
        WAIT_GAP = 3'd2,
        PRESS2   = 3'd3,
        HOLD     = 3'd4
    } state_t;

    localparam int LG_MAX    = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int CNT_TOP_I = (LG_MAX > REPEAT_CYCLES) ? LG_MAX : REPEAT_CYCLES;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_TOP_I);
    // Counts hold the number of samples already seen, so the deciding sample
    // is the one arriving while the counter sits one below the threshold.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_q;
    logic             pressed_q;
    logic             short_q;
    logic             double_q;
    logic             long_q;

    logic             rise_d;
    logic [CNT_W-1:0] cnt_inc_d;

    assign rise_d    = btn_level & ~btn_q;
    assign cnt_inc_d = (cnt_q >= CNT_TOP) ? cnt_q : cnt_q + CNT_ONE;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic rep_arm_q;
    logic repeat_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b1;
            pressed_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_arm_q <= 1'b0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            btn_q     <= btn_level;
            pressed_q <= btn_level;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rise_d) begin
                        state_q <= PRESS1;
                        cnt_q   <= CNT_ONE;
                    end
                end

                PRESS1: begin
                    if (btn_level) begin
                        if (cnt_q == LONG_LAST) begin
                            long_q  <= 1'b1;
                            state_q <= HOLD;
                            cnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
                            rep_arm_q <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end else if (GAP_CYCLES == 1) begin
                        // A one-sample gap is already closed by the release sample.
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= WAIT_GAP;
                        cnt_q   <= CNT_ONE;
                    end
                end

                WAIT_GAP: begin
                    if (btn_level) begin
                        state_q <= PRESS2;
                        cnt_q   <= CNT_ONE;
                    end else if (cnt_q == GAP_LAST) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                PRESS2: begin
                    if (!btn_level) begin
                        double_q <= 1'b1;
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        double_q <= 1'b1;
                        state_q  <= HOLD;
                        cnt_q    <= '0;
`ifdef AUTO_REPEAT_EN
                        rep_arm_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end

                HOLD: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
                        rep_arm_q <= 1'b0;
`endif
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_arm_q) begin
                        if (cnt_q == REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
`endif
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pressed      = pressed_q;
    assign busy         = (state_q != IDLE);
    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
`ifdef AUTO_REPEAT_EN
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Consumes the clean, debounced button level produced by the front-end debouncer and classifies presses into single-cycle event pulses: short press, double press and long press. It sits between the debouncer output and the 7-segment display control logic, which acts only on these pulses. The block is fully synchronous to the 50 MHz system clock.

Parameters:
LONG_CYCLES, 50_000_000, consecutive high samples that qualify a long press (1 s @ 50 MHz); must be >= 2
GAP_CYCLES, 12_500_000, consecutive low samples after a release that close the double-press window (250 ms); must be >= 1
REPEAT_CYCLES, 10_000_000, auto-repeat period in high samples after a long press (used only with AUTO_REPEAT_EN)
CNT_W, 26, counter width; must hold max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_level  input  1  debounced button level, synchronous to clk, 1 = pressed
pressed  output  1  registered copy of btn_level (1-cycle latency)
busy  output  1  1 whenever FSM is not in IDLE
short_press  output  1  one-cycle pulse: single short press completed
double_press  output  1  one-cycle pulse: second press of a double press
long_press  output  1  one-cycle pulse: long-press threshold reached
repeat_pulse  output  1  one-cycle auto-repeat pulse; constant 0 without AUTO_REPEAT_EN

Behaviour:
- Interface fixed: one clock clk; reset rst_n is asynchronous and active-low.
- Reset: state IDLE, counter 0, pressed=0, busy=0, all pulse outputs 0; internal previous-sample register btn_q resets to 1, so a button held through reset is ignored until a low sample is seen.
- Rise = btn_level=1 with btn_q=0; fall = btn_level=0 with btn_q=1. "Nth sample" = Nth consecutive rising edge sampling the given level, the edge of the rise/fall counting as sample 1.
- All pulses registered: asserted for exactly one cycle, the cycle after the deciding sample. At most one pulse per cycle.
- States:
  IDLE: on rise -> PRESS1, cnt=1.
  PRESS1: high -> cnt++; at LONG_CYCLES-th high sample -> long_press, -> HOLD. Fall -> WAIT_GAP, cnt=1.
  WAIT_GAP: low -> cnt++; at GAP_CYCLES-th low sample -> short_press, -> IDLE. Rise before that -> PRESS2, cnt=1.
  PRESS2: fall -> double_press, -> IDLE. At LONG_CYCLES-th high sample -> double_press, -> HOLD (no long_press).
  HOLD: wait while high; fall -> IDLE, no event.
- Counter saturates at its terminal value; never wraps.
- Third press arriving while in IDLE after a double press starts a fresh sequence.
- rst_n asserted mid-sequence: immediate return to reset values; pending events discarded.

Optional Feature:
AUTO_REPEAT_EN: when defined, HOLD entered via long_press emits repeat_pulse once every REPEAT_CYCLES further high samples while held (counter restarts after each pulse); HOLD entered from PRESS2 never repeats. When undefined, repeat_pulse is tied 0, no repeat counter logic is synthesized, and all other behaviour is identical.

Test Plan:
(Params LONG_CYCLES=20, GAP_CYCLES=8, REPEAT_CYCLES=5, CNT_W=8.)
1. Low 10, high 5, low 20 -> short_press one pulse in cycle after 8th low sample; no other pulses; busy 1 from rise until that pulse.
2. High 3, low 4, high 3, low 20 -> double_press one cycle after fall of second press; no short_press at any time.
3. High 30 then low -> long_press one pulse after 20th high sample; nothing on release; busy drops after fall.
4. Hold btn_level=1 through rst_n low/high, keep high 40 -> no pulses; then low 2, high 5, low 10 -> one short_press. Also assert rst_n mid-PRESS1 -> all outputs 0 next sample.
5. High 3, low 4, high 25 -> double_press after 20th high sample of second press; no long_press; nothing on release.
6. AUTO_REPEAT_EN defined: high 40 -> long_press at sample 20, repeat_pulse at samples 25, 30, 35, 40 (4 pulses); undefined: repeat_pulse stays 0.
